// File: rtl/htonl_ser.sv
// rtl/htonl_ser.sv - bit-serial host-to-network word transmitter with word FIFO
module htonl_ser #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bclk,
    input  logic [4:0]  counter,
    input  logic [31:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        out,
    output logic        underrun
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [31:0]   act_q;
    logic [31:0]   act_d;
    logic          bclk_prev_q;
    logic          out_q;
    logic          out_d;
    logic          underrun_q;

    logic          play;
    logic          boundary;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [4:0]    bit_idx;
    logic [31:0]   head;
    logic [31:0]   src;

    assign play     = bclk_prev_q && !bclk;
    assign boundary = play && (counter == 5'd0);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign push     = word_valid && !full;
    assign pop      = boundary && !empty;

    // Network order: byte 0 of the host word goes first, MSB-first within the byte.
    assign bit_idx  = {counter[4:3], ~counter[2:0]};

    always_comb begin
        head    = empty ? 32'd0 : mem_q[rd_ptr_q];
        src     = boundary ? head : act_q;
        act_d   = boundary ? head : act_q;
        out_d   = play ? src[bit_idx] : out_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            act_q       <= 32'd0;
            bclk_prev_q <= 1'b0;
            out_q       <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            bclk_prev_q <= bclk;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            act_q      <= act_d;
            out_q      <= out_d;
            underrun_q <= boundary && empty;
        end
    end

    assign word_ready = !full;
    assign out        = out_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_htonl_ser.sv
// tb/tb_htonl_ser.sv - directed self-checking bench for htonl_ser
module tb_htonl_ser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bclk = 1'b0;
    logic [4:0]  counter = 5'd0;
    logic [31:0] word_in = 32'd0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        out;
    logic        underrun;

    htonl_ser #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bclk       (bclk),
        .counter    (counter),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .out        (out),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;
    int boundary_cyc = 0;
    int accept_cyc = 0;
    int stable_err = 0;
    int ur_cnt = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] stream;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic play_bit(input logic [4:0] c, input int hi, input int lo,
                            input logic push_en, input logic [31:0] push_w, output logic b);
        logic prev;
        counter = c;
        bclk    = 1'b1;
        prev    = out;
        for (int i = 0; i < hi; i++) begin
            @(posedge clk); #1;
            if (out !== prev) stable_err++;
            if (underrun) ur_cnt++;
        end
        bclk = 1'b0;
        if (push_en) begin
            word_in    = push_w;
            word_valid = 1'b1;
        end
        @(posedge clk); #1;
        if (push_en) word_valid = 1'b0;
        b = out;
        if (underrun) ur_cnt++;
        if (c == 5'd0) boundary_cyc = cyc;
        for (int i = 1; i < lo; i++) begin
            @(posedge clk); #1;
            if (out !== b) stable_err++;
            if (underrun) ur_cnt++;
        end
    endtask

    task automatic run_word(input int hi, input int lo, input logic push_en,
                            input logic [31:0] push_w, output logic [31:0] got);
        logic        b;
        logic [31:0] acc;
        acc = 32'd0;
        for (int c = 0; c < 32; c++) begin
            play_bit(5'(c), hi, lo, (c == 0) && push_en, push_w, b);
            acc[31-c] = b;
        end
        got = acc;
    endtask

    task automatic push(input logic [31:0] w, input logic drop_valid);
        logic acc;
        acc        = 1'b0;
        word_in    = w;
        word_valid = 1'b1;
        for (int n = 0; n < 400 && !acc; n++) begin
            acc = word_ready;
            @(posedge clk); #1;
        end
        if (acc) accept_cyc = cyc;
        else check("push_timeout", {31'd0, acc}, 32'd1);
        if (drop_valid) word_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g1, g2, g3;
        logic        b;
        int          delta;
        logic        ready_full;

        vecs[0] = '{word: 32'h12345678, stream: 32'h78563412};
        vecs[1] = '{word: 32'hDEADBEEF, stream: 32'hEFBEADDE};
        vecs[2] = '{word: 32'h000000FF, stream: 32'hFF000000};
        vecs[3] = '{word: 32'h80000001, stream: 32'h01000080};
        vecs[4] = '{word: 32'hA5A5A5A5, stream: 32'hA5A5A5A5};

        repeat (2) @(posedge clk);
        #1;
        check("reset_out", {31'd0, out}, 32'd0);
        check("reset_underrun", {31'd0, underrun}, 32'd0);
        check("reset_ready", {31'd0, word_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            push(vecs[i].word, 1'b1);
            ur_cnt = 0;
            run_word(1, 1, 1'b0, 32'd0, g1);
            check($sformatf("vec%0d_stream", i), g1, vecs[i].stream);
            check($sformatf("vec%0d_underrun", i), ur_cnt, 32'd0);
        end

        push(32'hFFFFFFFF, 1'b1);
        push(32'h00000001, 1'b1);
        check("b2b_ready_full", {31'd0, word_ready}, 32'd0);
        ur_cnt = 0;
        run_word(1, 1, 1'b0, 32'd0, g1);
        check("b2b_ready_after_pop", {31'd0, word_ready}, 32'd1);
        run_word(1, 1, 1'b0, 32'd0, g2);
        check("b2b_word1", g1, 32'hFFFFFFFF);
        check("b2b_word2", g2, 32'h01000000);
        check("b2b_underrun", ur_cnt, 32'd0);

        ur_cnt = 0;
        delta = 0;
        ready_full = 1'b1;
        fork
            begin
                push(32'hA5A5A5A5, 1'b0);
                push(32'h5A5A5A5A, 1'b0);
                ready_full = word_ready;
                push(32'hDEADBEEF, 1'b1);
                delta = accept_cyc - boundary_cyc;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                run_word(1, 1, 1'b0, 32'd0, g1);
                run_word(1, 1, 1'b0, 32'd0, g2);
                run_word(1, 1, 1'b0, 32'd0, g3);
            end
        join
        check("full_ready_low", {31'd0, ready_full}, 32'd0);
        check("full_accept_delay", delta, 32'd1);
        check("full_word1", g1, 32'hA5A5A5A5);
        check("full_word2", g2, 32'h5A5A5A5A);
        check("full_word3", g3, 32'hEFBEADDE);
        check("full_underrun", ur_cnt, 32'd0);

        ur_cnt = 0;
        run_word(1, 1, 1'b1, 32'hDEADBEEF, g1);
        check("ur_out_zero", g1, 32'd0);
        check("ur_pulse_count", ur_cnt, 32'd1);
        ur_cnt = 0;
        run_word(1, 1, 1'b0, 32'd0, g2);
        check("ur_deferred_word", g2, 32'hEFBEADDE);
        check("ur_deferred_underrun", ur_cnt, 32'd0);

        push(32'hFFFFFFFF, 1'b1);
        push(32'hFFFFFFFF, 1'b1);
        play_bit(5'd0, 1, 1, 1'b0, 32'd0, b);
        push(32'hFFFFFFFF, 1'b1);
        for (int c = 1; c <= 12; c++) play_bit(5'(c), 1, 1, 1'b0, 32'd0, b);
        check("rst_pre_out", {31'd0, out}, 32'd1);
        check("rst_pre_ready", {31'd0, word_ready}, 32'd0);
        counter = 5'd13;
        bclk    = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_out", {31'd0, out}, 32'd0);
        check("rst_async_ready", {31'd0, word_ready}, 32'd1);
        check("rst_async_underrun", {31'd0, underrun}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(32'h000000FF, 1'b1);
        ur_cnt = 0;
        g1 = 32'd0;
        for (int c = 13; c < 32; c++) begin
            play_bit(5'(c), 1, 1, 1'b0, 32'd0, b);
            g1[31-c] = b;
        end
        check("rst_tail_zero", g1, 32'd0);
        check("rst_tail_underrun", ur_cnt, 32'd0);
        run_word(1, 1, 1'b0, 32'd0, g2);
        check("rst_post_word", g2, 32'hFF000000);
        check("rst_post_underrun", ur_cnt, 32'd0);
        run_word(1, 1, 1'b0, 32'd0, g3);
        check("rst_empty_word", g3, 32'd0);
        check("rst_empty_underrun", ur_cnt, 32'd1);

        push(32'h12345678, 1'b1);
        stable_err = 0;
        ur_cnt = 0;
        run_word(3, 1, 1'b0, 32'd0, g1);
        check("rise_stream", g1, 32'h78563412);
        check("rise_stable", stable_err, 32'd0);
        check("rise_underrun", ur_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
